// File: rtl/bp_cacc_vdp_sched.sv
// Round-robin job scheduler for the vector dot-product accelerator: programs the
// CSRs of one granted job, starts it, polls status and returns a completion record.
module bp_cacc_vdp_sched #(
    parameter int num_req_p    = 2,
    parameter int poll_limit_p = 1024,
    localparam int id_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int cnt_w_lp = $clog2(poll_limit_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [num_req_p-1:0]      req_v_i,
    output logic [num_req_p-1:0]      req_ready_o,
    input  logic [num_req_p*64-1:0]   req_a_ptr_i,
    input  logic [num_req_p*64-1:0]   req_b_ptr_i,
    input  logic [num_req_p*64-1:0]   req_res_ptr_i,
    input  logic [num_req_p*4-1:0]    req_len_i,
    output logic                      csr_v_o,
    output logic                      csr_w_o,
    output logic [19:0]               csr_addr_o,
    output logic [63:0]               csr_data_o,
    input  logic                      csr_ready_i,
    input  logic                      csr_resp_v_i,
    input  logic [63:0]               csr_resp_data_i,
    output logic                      csr_resp_yumi_o,
    output logic                      done_v_o,
    output logic [id_w_lp-1:0]        done_id_o,
    output logic                      done_err_o,
    input  logic                      done_ready_i,
    output logic                      halted_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_WR, S_POLL, S_WAIT_RD, S_REPORT, S_HALT
    } state_e;

    localparam logic [19:0] STATUS_ADDR = 20'h100;

    state_e                state_r;
    logic [id_w_lp-1:0]    rr_ptr_r;
    logic [2:0]            step_r;
    logic                  halt_r;
    logic [cnt_w_lp-1:0]   poll_cnt_r;
    logic                  csr_v_r;
    logic                  csr_w_r;
    logic [19:0]           csr_addr_r;
    logic [63:0]           csr_data_r;
    logic                  done_v_r;
    logic [id_w_lp-1:0]    done_id_r;
    logic                  done_err_r;

    // Latched job fields; these carry no reset since nothing reads them outside a job.
    logic [id_w_lp-1:0]    id_r;
    logic [63:0]           a_r;
    logic [63:0]           b_r;
    logic [63:0]           res_r;
    logic [3:0]            len_r;

    logic [num_req_p-1:0]  grant;
    logic [id_w_lp-1:0]    win;
    logic                  found;
    int                    idx;
    logic [63:0]           win_a;
    logic [63:0]           win_b;
    logic [63:0]           win_res;
    logic [3:0]            win_len;
    logic                  win_len_bad;
    logic [cnt_w_lp-1:0]   poll_cnt_nxt;

    function automatic logic [19:0] wr_addr(input logic [2:0] step);
        case (step)
            3'd0:    return 20'h000;
            3'd1:    return 20'h040;
            3'd2:    return 20'h080;
            3'd3:    return 20'h140;
            3'd4:    return 20'h180;
            default: return 20'h0c0;
        endcase
    endfunction

    // Steps 4 (result length) and 5 (start) both write the constant 1.
    function automatic logic [63:0] wr_data(input logic [2:0] step, input logic [63:0] a,
                                            input logic [63:0] b, input logic [63:0] res,
                                            input logic [3:0] len);
        case (step)
            3'd0:    return a;
            3'd1:    return b;
            3'd2:    return {60'd0, len};
            3'd3:    return res;
            default: return 64'd1;
        endcase
    endfunction

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = (int'(rr_ptr_r) + i) % num_req_p;
            if (!found && req_v_i[idx]) begin
                grant[idx] = 1'b1;
                win        = id_w_lp'(idx);
                found      = 1'b1;
            end
        end
        if (state_r != S_IDLE) grant = '0;
    end

    assign win_a        = req_a_ptr_i[int'(win)*64 +: 64];
    assign win_b        = req_b_ptr_i[int'(win)*64 +: 64];
    assign win_res      = req_res_ptr_i[int'(win)*64 +: 64];
    assign win_len      = req_len_i[int'(win)*4 +: 4];
    assign win_len_bad  = (win_len == 4'd0) || (win_len > 4'd8);
    assign poll_cnt_nxt = poll_cnt_r + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= S_IDLE;
            rr_ptr_r   <= '0;
            step_r     <= '0;
            halt_r     <= 1'b0;
            poll_cnt_r <= '0;
            csr_v_r    <= 1'b0;
            csr_w_r    <= 1'b0;
            csr_addr_r <= '0;
            csr_data_r <= '0;
            done_v_r   <= 1'b0;
            done_id_r  <= '0;
            done_err_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: if (found) begin
                    id_r     <= win;
                    a_r      <= win_a;
                    b_r      <= win_b;
                    res_r    <= win_res;
                    len_r    <= win_len;
                    rr_ptr_r <= (int'(win) == num_req_p - 1) ? '0 : win + 1'b1;
                    if (win_len_bad) begin
                        state_r    <= S_REPORT;
                        done_v_r   <= 1'b1;
                        done_id_r  <= win;
                        done_err_r <= 1'b1;
                    end else begin
                        state_r    <= S_ISSUE;
                        step_r     <= 3'd0;
                        csr_v_r    <= 1'b1;
                        csr_w_r    <= 1'b1;
                        csr_addr_r <= wr_addr(3'd0);
                        csr_data_r <= wr_data(3'd0, win_a, win_b, win_res, win_len);
                    end
                end
                S_ISSUE: if (csr_ready_i) begin
                    csr_v_r <= 1'b0;
                    state_r <= S_WAIT_WR;
                end
                S_WAIT_WR: if (csr_resp_v_i) begin
                    csr_v_r <= 1'b1;
                    if (step_r == 3'd5) begin
                        state_r    <= S_POLL;
                        poll_cnt_r <= '0;
                        csr_w_r    <= 1'b0;
                        csr_addr_r <= STATUS_ADDR;
                        csr_data_r <= '0;
                    end else begin
                        state_r    <= S_ISSUE;
                        step_r     <= step_r + 3'd1;
                        csr_addr_r <= wr_addr(step_r + 3'd1);
                        csr_data_r <= wr_data(step_r + 3'd1, a_r, b_r, res_r, len_r);
                    end
                end
                S_POLL: if (csr_ready_i) begin
                    csr_v_r <= 1'b0;
                    state_r <= S_WAIT_RD;
                end
                S_WAIT_RD: if (csr_resp_v_i) begin
                    poll_cnt_r <= poll_cnt_nxt;
                    if (csr_resp_data_i != 64'd0) begin
                        state_r    <= S_REPORT;
                        done_v_r   <= 1'b1;
                        done_id_r  <= id_r;
                        done_err_r <= 1'b0;
                    end else if (poll_cnt_nxt == cnt_w_lp'(poll_limit_p)) begin
                        state_r    <= S_REPORT;
                        done_v_r   <= 1'b1;
                        done_id_r  <= id_r;
                        done_err_r <= 1'b1;
                        halt_r     <= 1'b1;
                    end else begin
                        state_r <= S_POLL;
                        csr_v_r <= 1'b1;
                    end
                end
                S_REPORT: if (done_ready_i) begin
                    done_v_r <= 1'b0;
                    state_r  <= halt_r ? S_HALT : S_IDLE;
                end
                default: state_r <= S_HALT;
            endcase
        end
    end

    assign req_ready_o     = grant;
    assign csr_v_o         = csr_v_r;
    assign csr_w_o         = csr_w_r;
    assign csr_addr_o      = csr_addr_r;
    assign csr_data_o      = csr_data_r;
    assign csr_resp_yumi_o = csr_resp_v_i;
    assign done_v_o        = done_v_r;
    assign done_id_o       = done_id_r;
    assign done_err_o      = done_err_r;
    assign halted_o        = halt_r;

endmodule

// File: tb/tb_bp_cacc_vdp_sched.sv
// Bench for bp_cacc_vdp_sched: requester queues, a CSR adapter model with status
// replay and stalls, and an expected command stream derived from each job.
module tb_bp_cacc_vdp_sched;
    localparam int NREQ = 2;
    localparam int PLIM = 4;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic [NREQ-1:0]      req_v_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*64-1:0]   req_a_ptr_i, req_b_ptr_i, req_res_ptr_i;
    logic [NREQ*4-1:0]    req_len_i;
    logic                 csr_v_o, csr_w_o, csr_ready_i;
    logic [19:0]          csr_addr_o;
    logic [63:0]          csr_data_o;
    logic                 csr_resp_v_i, csr_resp_yumi_o;
    logic [63:0]          csr_resp_data_i;
    logic                 done_v_o, done_err_o, done_ready_i, halted_o;
    logic [0:0]           done_id_o;

    always #5 clk = ~clk;

    bp_cacc_vdp_sched #(.num_req_p(NREQ), .poll_limit_p(PLIM)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
        .req_a_ptr_i(req_a_ptr_i), .req_b_ptr_i(req_b_ptr_i), .req_res_ptr_i(req_res_ptr_i),
        .req_len_i(req_len_i), .csr_v_o(csr_v_o), .csr_w_o(csr_w_o), .csr_addr_o(csr_addr_o),
        .csr_data_o(csr_data_o), .csr_ready_i(csr_ready_i), .csr_resp_v_i(csr_resp_v_i),
        .csr_resp_data_i(csr_resp_data_i), .csr_resp_yumi_o(csr_resp_yumi_o),
        .done_v_o(done_v_o), .done_id_o(done_id_o), .done_err_o(done_err_o),
        .done_ready_i(done_ready_i), .halted_o(halted_o)
    );

    typedef struct packed { logic [63:0] a; logic [63:0] b; logic [63:0] r; logic [3:0] len; } job_t;
    typedef struct packed { logic w; logic [19:0] addr; logic [63:0] data; } cmd_t;
    typedef struct { int id; logic err; int cyc; } done_t;

    job_t        jq0[$], jq1[$];
    logic [63:0] status_q[$];
    cmd_t        cmd_log[$], exp_cmd[$];
    int          cmd_cyc[$];
    done_t       done_log[$];
    int          grant_log[$], grant_cyc[$];

    int checks = 0, errors = 0;
    int cyc = 0, m_rr = 0;
    int csr_v_seen, resp_cnt, yumi_bad, onehot_bad;
    int stall_cnt, stall_unstable, dstall_left, dstall_hold, done_drop, resp_extra;
    logic stall_arm, dstall_started;

    assign csr_ready_i = !(stall_arm && csr_v_o && csr_w_o && csr_addr_o == 20'h080);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        cmd_log.delete(); cmd_cyc.delete(); exp_cmd.delete(); done_log.delete();
        grant_log.delete(); grant_cyc.delete();
        csr_v_seen = 0; resp_cnt = 0; stall_cnt = 0; stall_unstable = 0;
        dstall_hold = 0; done_drop = 0; dstall_started = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        clear_logs();
    endtask

    function automatic job_t rjob(input logic [3:0] len);
        job_t j;
        j.a = {$urandom, $urandom};
        j.b = {$urandom, $urandom};
        j.r = {$urandom, $urandom};
        j.len = len;
        return j;
    endfunction

    task automatic add_job(input int r, input job_t j);
        if (r == 0) jq0.push_back(j);
        else        jq1.push_back(j);
    endtask

    // A valid job writes the six CSRs in order, then issues one status read per poll.
    task automatic push_exp(input job_t j, input int polls);
        exp_cmd.push_back({1'b1, 20'h000, j.a});
        exp_cmd.push_back({1'b1, 20'h040, j.b});
        exp_cmd.push_back({1'b1, 20'h080, {60'd0, j.len}});
        exp_cmd.push_back({1'b1, 20'h140, j.r});
        exp_cmd.push_back({1'b1, 20'h180, 64'd1});
        exp_cmd.push_back({1'b1, 20'h0c0, 64'd1});
        for (int p = 0; p < polls; p++) exp_cmd.push_back({1'b0, 20'h100, 64'd0});
    endtask

    task automatic compare_cmds(input string tag);
        int n;
        check({tag, "_cmd_count"}, cmd_log.size(), exp_cmd.size());
        n = (cmd_log.size() < exp_cmd.size()) ? cmd_log.size() : exp_cmd.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_cmd[i]);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_log.size() < n && k < budget) begin tick(); k++; end
        check("done_count", done_log.size(), n);
    endtask

    // Environment: samples mid-cycle, drives requesters and the adapter just after the edge.
    initial begin : env
        logic acc, dec_d, rst_seen, pend;
        int gi, expw, pend_left;
        logic [63:0] pd, pend_data;
        logic [83:0] cap_ad;
        pend = 1'b0; pend_left = 0; pend_data = '0; pd = '0; cap_ad = '0;
        forever begin
            @(negedge clk);
            acc = csr_v_o && csr_ready_i;
            if (csr_v_o) csr_v_seen++;
            if (csr_resp_v_i) resp_cnt++;
            if (csr_resp_v_i && !csr_resp_yumi_o) yumi_bad++;
            if (acc) begin
                cmd_log.push_back({csr_w_o, csr_addr_o, csr_data_o});
                cmd_cyc.push_back(cyc);
                if (csr_w_o) pd = '0;
                else if (status_q.size() > 0) pd = status_q.pop_front();
                else pd = '0;
            end
            if (csr_v_o && !csr_ready_i) begin
                if (stall_cnt == 0) cap_ad = {csr_addr_o, csr_data_o};
                else if (cap_ad !== {csr_addr_o, csr_data_o}) stall_unstable++;
                stall_cnt++;
            end
            dec_d = done_v_o && !done_ready_i;
            if (dec_d) dstall_hold++;
            if (dstall_started && dstall_left > 0 && !done_v_o) done_drop++;
            if (done_v_o && done_ready_i) done_log.push_back('{int'(done_id_o), done_err_o, cyc});
            if ($countones(req_ready_o) > 1) onehot_bad++;
            gi = -1;
            if (!reset_i)
                for (int i = 0; i < NREQ; i++) if (req_v_i[i] && req_ready_o[i]) gi = i;
            if (gi >= 0) begin
                expw = -1;
                for (int i = 0; i < NREQ; i++)
                    if (expw < 0 && req_v_i[(m_rr + i) % NREQ]) expw = (m_rr + i) % NREQ;
                check("rr_winner", gi, expw);
                m_rr = (expw + 1) % NREQ;
                grant_log.push_back(gi);
                grant_cyc.push_back(cyc);
            end
            rst_seen = reset_i;
            @(posedge clk);
            cyc++;
            #1;
            if (rst_seen) m_rr = 0;
            csr_resp_v_i = 1'b0;
            if (pend) begin
                pend_left--;
                if (pend_left == 0) begin
                    csr_resp_v_i = 1'b1; csr_resp_data_i = pend_data; pend = 1'b0;
                end
            end
            if (acc) begin
                if (resp_extra == 0) begin csr_resp_v_i = 1'b1; csr_resp_data_i = pd; end
                else begin pend = 1'b1; pend_left = resp_extra; pend_data = pd; end
            end
            if (stall_arm && stall_cnt >= 5) stall_arm = 1'b0;
            if (dec_d && dstall_left > 0) begin dstall_left--; dstall_started = 1'b1; end
            done_ready_i = (dstall_left == 0);
            if (gi == 0) void'(jq0.pop_front());
            else if (gi == 1) void'(jq1.pop_front());
            req_v_i = {jq1.size() != 0, jq0.size() != 0};
            req_a_ptr_i = '0; req_b_ptr_i = '0; req_res_ptr_i = '0; req_len_i = '0;
            if (jq0.size() != 0) begin
                req_a_ptr_i[63:0] = jq0[0].a; req_b_ptr_i[63:0] = jq0[0].b;
                req_res_ptr_i[63:0] = jq0[0].r; req_len_i[3:0] = jq0[0].len;
            end
            if (jq1.size() != 0) begin
                req_a_ptr_i[127:64] = jq1[0].a; req_b_ptr_i[127:64] = jq1[0].b;
                req_res_ptr_i[127:64] = jq1[0].r; req_len_i[7:4] = jq1[0].len;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : main
        job_t j;
        int k, g, z;
        reset_i = 1'b1; req_v_i = '0; req_a_ptr_i = '0; req_b_ptr_i = '0;
        req_res_ptr_i = '0; req_len_i = '0; csr_resp_v_i = 1'b0; csr_resp_data_i = '0;
        done_ready_i = 1'b1; stall_arm = 1'b0; dstall_left = 0; resp_extra = 0;
        yumi_bad = 0; onehot_bad = 0;
        clear_logs();
        tick();
        do_reset();

        // Reset state.
        check("rst_csr_v", csr_v_o, 0);
        check("rst_csr_w", csr_w_o, 0);
        check("rst_csr_addr", csr_addr_o, 0);
        check("rst_csr_data", csr_data_o, 0);
        check("rst_done_v", done_v_o, 0);
        check("rst_done_id", done_id_o, 0);
        check("rst_done_err", done_err_o, 0);
        check("rst_halted", halted_o, 0);
        check("rst_ready", req_ready_o, 0);

        // Single job on requester 0 with status 0,0,1.
        j = '{a: 64'h8000_0000, b: 64'h8000_0100, r: 64'h8000_0200, len: 4'd4};
        status_q = '{64'd0, 64'd0, 64'd1};
        push_exp(j, 3);
        add_job(0, j);
        wait_done(1, 100);
        compare_cmds("single");
        g = grant_cyc[0];
        check("single_id", done_log[0].id, 0);
        check("single_err", done_log[0].err, 0);
        check("single_done_cyc", done_log[0].cyc - g, 19);
        check("single_wr0_cyc", cmd_cyc[0] - g, 1);
        check("single_start_cyc", cmd_cyc[5] - g, 11);
        check("single_poll0_cyc", cmd_cyc[6] - g, 13);

        // Round robin: three random jobs per requester, random status replay.
        do_reset();
        status_q.delete();
        for (int n = 0; n < 6; n++) begin
            j = rjob(4'($urandom_range(1, 8)));
            z = $urandom_range(0, 2);
            for (int p = 0; p < z; p++) status_q.push_back(64'd0);
            status_q.push_back({$urandom, $urandom | 32'd1});
            push_exp(j, z + 1);
            add_job(n % 2, j);
        end
        wait_done(6, 600);
        compare_cmds("rr");
        for (int n = 0; n < 6; n++) begin
            check($sformatf("rr_grant%0d", n), grant_log[n], n % 2);
            check($sformatf("rr_done_id%0d", n), done_log[n].id, n % 2);
            check($sformatf("rr_done_err%0d", n), done_log[n].err, 0);
        end

        // Length bounds: 0 and 9 rejected with no CSR traffic, 8 accepted.
        do_reset();
        add_job(0, rjob(4'd0));
        wait_done(1, 20);
        add_job(0, rjob(4'd9));
        wait_done(2, 20);
        check("len0_err", done_log[0].err, 1);
        check("len9_err", done_log[1].err, 1);
        check("len0_done_cyc", done_log[0].cyc - grant_cyc[0], 1);
        check("len_bad_no_csr_v", csr_v_seen, 0);
        check("len_bad_no_cmd", cmd_log.size(), 0);
        j = rjob(4'd8);
        status_q = '{64'd5};
        push_exp(j, 1);
        add_job(0, j);
        wait_done(3, 100);
        compare_cmds("len8");
        check("len8_err", done_log[2].err, 0);

        // Backpressure: ready stalls on the len write, slow responses, slow completion sink.
        do_reset();
        stall_arm = 1'b1; resp_extra = 3; dstall_left = 4;
        j = rjob(4'd5);
        status_q = '{64'd1};
        push_exp(j, 1);
        add_job(1, j);
        wait_done(1, 300);
        compare_cmds("bp");
        check("bp_stall_cycles", stall_cnt, 5);
        check("bp_stable", stall_unstable, 0);
        check("bp_done_hold", dstall_hold, 4);
        check("bp_done_drop", done_drop, 0);
        check("bp_done_id", done_log[0].id, 1);
        check("bp_done_err", done_log[0].err, 0);
        check("bp_done_cyc", done_log[0].cyc - grant_cyc[0], 45);
        resp_extra = 0;

        // Reset while waiting on a status read; the late response is dropped in IDLE.
        do_reset();
        resp_extra = 3;
        status_q = '{64'd0, 64'd0};
        add_job(0, rjob(4'd3));
        k = 0;
        while (cmd_log.size() < 7 && k < 100) begin tick(); k++; end
        check("midpoll_reached", cmd_log.size(), 7);
        do_reset();
        check("midpoll_csr_v", csr_v_o, 0);
        check("midpoll_csr_addr", csr_addr_o, 0);
        check("midpoll_done_v", done_v_o, 0);
        check("midpoll_halted", halted_o, 0);
        repeat (6) tick();
        check("midpoll_stale_seen", resp_cnt, 1);
        check("midpoll_idle_csr_v", csr_v_seen, 0);
        check("midpoll_idle_done", done_log.size(), 0);
        resp_extra = 0;
        status_q = '{64'd1, 64'd1};
        add_job(0, rjob(4'd2));
        add_job(1, rjob(4'd7));
        wait_done(2, 200);
        check("midpoll_rr_restart", grant_log[0], 0);
        check("midpoll_after_id0", done_log[0].id, 0);
        check("midpoll_after_err0", done_log[0].err, 0);

        // Timeout: status stays zero, four polls, then halt until reset.
        do_reset();
        status_q.delete();
        j = rjob(4'd6);
        push_exp(j, PLIM);
        add_job(0, j);
        wait_done(1, 200);
        compare_cmds("timeout");
        check("timeout_err", done_log[0].err, 1);
        check("timeout_halted", halted_o, 1);
        grant_log.delete();
        csr_v_seen = 0;
        add_job(1, rjob(4'd2));
        repeat (30) tick();
        check("halt_no_grant", grant_log.size(), 0);
        check("halt_ready", req_ready_o, 0);
        check("halt_no_csr", csr_v_seen, 0);
        check("halt_sticky", halted_o, 1);
        do_reset();
        check("halt_cleared", halted_o, 0);
        status_q = '{64'd1};
        wait_done(1, 100);
        check("post_halt_id", done_log[0].id, 1);
        check("post_halt_err", done_log[0].err, 0);

        check("resp_always_consumed", yumi_bad, 0);
        check("grant_onehot", onehot_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
